// File: rtl/bus_arb_mux_pkg.sv
// Shared constants, helpers and types for the bus_arb_mux N-channel bus multiplexer.
package bus_arb_mux_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int NUM_CH_DEF = 4;

    // Channel index as seen by the datapath's bus sources at the default channel count.
    typedef logic [$clog2(NUM_CH_DEF)-1:0] bus_ch_t;

    function automatic int next_idx(input int idx, input int num_ch);
        return (idx + 1 >= num_ch) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arb_mux_rr_priority_pick.sv
// Combinational priority pick: scans eligible channels starting at ptr, wrapping,
// and returns a one-hot grant plus its encoded index.
module rr_priority_pick #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] elig,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx
);

    int c;

    // Walk from the farthest offset back to ptr so the closest eligible channel wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        c     = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (elig[c]) begin
                grant    = '0;
                grant[c] = 1'b1;
                idx      = CH_W'(c);
            end
        end
    end

endmodule

// File: rtl/bus_arb_mux.sv
// Registered N:1 valid/ready bus multiplexer with forced-select override.
// Define BUS_ARB_MUX_RR_EN for round-robin arbitration; otherwise lowest index wins.
module bus_arb_mux
    import bus_arb_mux_pkg::*;
#(
    parameter  int WIDTH  = WIDTH_DEF,
    parameter  int NUM_CH = NUM_CH_DEF,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    force_en,
    input  logic [CH_W-1:0]         force_sel,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;

    logic [NUM_CH-1:0] sel_mask, elig, grant;
    logic [CH_W-1:0]   grant_idx, ptr;
    logic [WIDTH-1:0]  grant_word;
    logic              load_ok, xfer;

    assign load_ok = !out_valid_q || out_ready;

    // Out-of-range force_sel leaves the mask empty, so nothing is eligible.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_CH; i++)
            sel_mask[i] = (int'(force_sel) == i);
    end

    assign elig = force_en ? (in_valid & sel_mask) : in_valid;

    rr_priority_pick #(.NUM_CH(NUM_CH)) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign in_ready = (rst_n && load_ok) ? grant : '0;
    assign xfer     = |in_ready;

    // One-hot AND-OR select keeps in_data out of any ready path.
    always_comb begin
        grant_word = '0;
        for (int i = 0; i < NUM_CH; i++)
            grant_word = grant_word | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_word;
            out_ch_d    = grant_idx;
        end else if (load_ok) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

`ifdef BUS_ARB_MUX_RR_EN
    logic [CH_W-1:0] ptr_q, ptr_d;

    // Forced transfers move the pointer too, so fairness resumes after the override.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = CH_W'(next_idx(int'(grant_idx), NUM_CH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Scoreboard bench for bus_arb_mux (default 8-bit, 4-channel build; either arbitration mode).
module tb_bus_arb_mux;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            force_en;
    logic [CW-1:0]   force_sel;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [CW-1:0]   out_ch;
    logic            out_ready;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [CW-1:0] ch;
    } sb_t;

    sb_t sb[$];
    int  mptr;
    int  n_chk = 0;
    int  n_fail = 0;

    always #5 clk = ~clk;

    bus_arb_mux dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference arbiter: search from the model pointer over the eligible set.
    function automatic logic [N-1:0] mdl_grant();
        logic [N-1:0] e;
        int c;
        e = force_en ? (in_valid & (N'(1) << force_sel)) : in_valid;
        if (!rst_n || !(sb.size() == 0 || out_ready)) return '0;
        for (int k = 0; k < N; k++) begin
            c = (mptr + k) % N;
            if (e[c]) return N'(1) << c;
        end
        return '0;
    endfunction

    // Called at posedge+1 with inputs set; checks at the negedge, updates the model at posedge.
    task automatic tick();
        logic [N-1:0] g;
        sb_t          s;
        #4;
        g = mdl_grant();
        check("in_ready", 32'(in_ready), 32'(g));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("out_data", 32'(out_data), 32'(sb[0].d));
            check("out_ch", 32'(out_ch), 32'(sb[0].ch));
        end
        @(posedge clk);
        if (!rst_n) begin
            sb.delete();
            mptr = 0;
        end else begin
            if (sb.size() != 0 && out_ready) void'(sb.pop_front());
            for (int c = 0; c < N; c++) begin
                if (g[c]) begin
                    s.d  = in_data[c*W +: W];
                    s.ch = CW'(c);
                    sb.push_back(s);
`ifdef BUS_ARB_MUX_RR_EN
                    mptr = (c + 1) % N;
`endif
                end
            end
        end
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_data   = 32'h44_33_22_11;
        force_en  = 1'b0;
        force_sel = '0;
        out_ready = 1'b1;
        mptr      = 0;
        @(posedge clk);
        #1;

        // Reset and idle with every channel requesting
        repeat (3) tick();
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_ch", 32'(out_ch), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);

        // Single channel 2
        rst_n    = 1'b1;
        in_valid = 4'b0100;
        in_data  = 32'h00_A5_00_00;
        tick();
        in_valid = 4'b0000;
        #4;
        check("single_data", 32'(out_data), 32'hA5);
        check("single_ch", 32'(out_ch), 32'h2);
        #1;
        @(posedge clk);
        #1;
        void'(sb.pop_front());
        check("single_drain", 32'(out_valid), 32'h0);

        // All channels valid, streaming
        in_valid = 4'hF;
        in_data  = 32'hD3_C2_B1_A0;
        repeat (5) tick();

        // Backpressure with a full register, then release
        out_ready = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        repeat (2) tick();

        // Forced select
        force_en  = 1'b1;
        force_sel = 2'd3;
        in_valid  = 4'b1001;
        repeat (2) tick();
        in_valid  = 4'b0001;
        repeat (2) tick();
        force_en  = 1'b0;

        // Reset while the register is full and stalled
        in_valid = 4'hF;
        tick();
        out_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_valid", 32'(out_valid), 32'h0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (2) tick();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            in_valid  = N'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            force_en  = ($urandom_range(0, 4) == 0);
            force_sel = CW'($urandom_range(0, 3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arb_mux.md
# bus_arb_mux

Parametrised, registered N-channel bus multiplexer for the 8-bit datapath: it arbitrates between `NUM_CH` valid/ready source channels and forwards one `WIDTH`-bit word per cycle into a single output register. It is the next generation of the datapath's combinational 2:1 operand select, adding the following:

- any channel count;
- backpressure;
- a forced-select override that reproduces plain select-line behaviour.

It sits between the register file, ALU and immediate sources and the shared internal data bus.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits (≥1).
- `NUM_CH`, 4, number of source channels (≥2).
- `CH_W`, `$clog2(NUM_CH)` (derived, not overridden), width of channel index.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in `NUM_CH`: per-channel word available.
- `in_data` in `NUM_CH*WIDTH`: channel `i` occupies `in_data[i*WIDTH +: WIDTH]`.
- `in_ready` out `NUM_CH`: one-hot or zero; channel word accepted this cycle when `in_valid[i] && in_ready[i]`.
- `force_en` in 1: 1 means arbitration is bypassed and only `force_sel` is eligible.
- `force_sel` in `CH_W`: forced channel index.
- `out_valid` out 1: output register holds a word.
- `out_data` out `WIDTH`: registered word.
- `out_ch` out `CH_W`: index of the channel that supplied `out_data`.
- `out_ready` in 1: downstream accepts when `out_valid && out_ready`.

## Operation
- Load slot: `load_ok = !out_valid || out_ready`.
- Eligible set:
  - `force_en = 0`: eligible is `in_valid`.
  - `force_en = 1`: eligible is `in_valid & (1 << force_sel)`.
  - `force_sel ≥ NUM_CH`: eligible is empty.
- Grant: when `load_ok`, exactly one eligible channel is granted per the priority rule (see Configuration), and `in_ready = grant`. Otherwise `in_ready = 0`.
- Valid/data rules:
  - Sources hold `in_valid` and data stable until accepted.
  - `in_valid` never depends on `in_ready`.
- On a transfer:
  - `out_data` takes the granted word.
  - `out_ch` takes the granted index.
  - `out_valid` is set to 1.
- `load_ok` with nothing eligible: if `out_ready` drained the register, `out_valid` is cleared. `out_data` and `out_ch` hold their last values.
- Simultaneous drain and load in the same cycle: the new word replaces the old. No bubble; throughput is 1 word/cycle.
- `out_valid && !out_ready`: all outputs hold and `in_ready = 0`.
- `force_en` changes take effect in the same cycle. A word already in the output register is unaffected.

## Timing
- Latency: 1 cycle from input acceptance to `out_valid`.
- `in_ready` is combinational from `in_valid`, `force_*`, `out_ready`, `out_valid` and the priority pointer. There is no combinational path from `in_data`.
- Reset (`rst_n = 0` at a rising edge):
  - `out_valid = 0`, `out_data = 0`, `out_ch = 0`, priority pointer `= 0`.
  - `in_ready = 0` while `rst_n = 0`.
  - Reset mid-transfer discards the registered word. No transfer is counted in the reset cycle.
- First grant is possible in the cycle after `rst_n` returns high.

## Configuration
- `BUS_ARB_MUX_RR_EN` defined: round-robin.
  - A pointer `ptr` (`CH_W` bits) gives the highest-priority index. Search goes `ptr`, `ptr+1`, …, wrapping at `NUM_CH-1` to 0.
  - After each transfer from channel `g`, `ptr = (g+1) mod NUM_CH`. The pointer is unchanged when no transfer occurs.
  - Forced transfers also update `ptr`.
- Not defined: fixed priority, with the lowest eligible index winning. The pointer register is not instantiated.

## Structure
- Package `bus_arb_mux_pkg`:
  - default `WIDTH`/`NUM_CH` constants;
  - function `next_idx(idx, num_ch)` for wrap-around increment;
  - typedef for the channel index used by the datapath's bus sources.
- Sub-module `rr_priority_pick`: combinational; takes the eligible vector and start pointer and returns a one-hot grant plus an encoded index. Under fixed priority it is driven with a pointer of 0.

## Test plan
1. Reset and idle: hold `rst_n = 0` for 3 cycles with all `in_valid = 1`. Required response: `in_ready = 0`, `out_valid = 0`, `out_data = 0`, `out_ch = 0`.
2. Single channel: `in_valid = 4'b0100`, data `8'hA5`, `out_ready = 1`. Required response: `in_ready = 4'b0100` in cycle 0; the next cycle shows `out_valid = 1`, `out_data = 8'hA5`, `out_ch = 2`.
3. Round-robin (RR_EN), all four channels continuously valid, `out_ready = 1`. Required response: `out_ch` sequence 0,1,2,3,0, with one word per cycle and no bubbles. Without the macro, `out_ch` stays 0.
4. Backpressure: `out_ready = 0` for 4 cycles with the register full. Required response: `in_ready = 0` and `out_data` stable. On `out_ready = 1`, the next word loads in the same cycle.
5. Force:
   - `force_en = 1`, `force_sel = 3`, `in_valid = 4'b1001`. Required response: only channel 3 is granted.
   - `force_sel = 3` with `in_valid = 4'b0001`. Required response: no grant, and `out_valid` falls after the drain.
6. Reset mid-stream: assert `rst_n = 0` while `out_valid = 1` and `out_ready = 0`. Required response: the next cycle has `out_valid = 0` and the pointer at 0.
